// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants and write-back source encoding
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC8  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_decode.sv
// rtl/wb_decode.sv - W-stage instruction class to write-back source decode
//
// Ports:
//   instr   in   32  instruction word in W (32'h0 is a bubble)
//   wb_src  out  2   write-back source (WB_NONE when nothing is written)
module wb_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output wb_src_e     wb_src
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    always_comb begin
        wb_src = WB_NONE;
        // The bubble encodes as sll $0,$0,0; it must not look like an R-type write.
        if (instr != 32'h0) begin
            unique case (op)
                OP_RTYPE: begin
                    if (funct == FN_JALR)
                        wb_src = WB_PC8;
                    else if (funct != FN_JR)
                        wb_src = WB_ALU;
                end
                OP_JAL:                     wb_src = WB_PC8;
                OP_LW:                      wb_src = WB_MEM;
                OP_ORI, OP_LUI, OP_ADDIU:   wb_src = WB_ALU;
                default:                    wb_src = WB_NONE;
            endcase
        end
    end

endmodule

// File: rtl/w_writeback_grf.sv
// rtl/w_writeback_grf.sv - write-back select, 31x32 register file with bypass, instret
//
// Ports:
//   clk, reset (async active-low)
//   W_PC, W_inStr, W_PC8, W_writeReg_NUM, W_dataOUT, W_aluResult : W-stage bundle
//   D_rs_NUM, D_rt_NUM / D_rs_data, D_rt_data : D-stage read ports, write-through bypass
//   W_we, W_wdata : committed write this cycle (forwarding source)
//   trace_valid, trace_pc, trace_reg, trace_data : per-write debug trace
//   instret : retired-instruction counter
module w_writeback_grf
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_inStr,
    input  logic [31:0] W_PC8,
    input  logic [4:0]  W_writeReg_NUM,
    input  logic [31:0] W_dataOUT,
    input  logic [31:0] W_aluResult,
    input  logic [4:0]  D_rs_NUM,
    input  logic [4:0]  D_rt_NUM,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic        W_we,
    output logic [31:0] W_wdata,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_reg,
    output logic [31:0] trace_data,
    output logic [31:0] instret
);

    wb_src_e     wb_src;
    logic [31:0] grf_q [1:31];
    logic [31:0] grf_d [1:31];
    logic [31:0] grf_view [0:31];
    logic [31:0] instret_q;
    logic [31:0] instret_d;

    wb_decode u_wb_decode (
        .instr  (W_inStr),
        .wb_src (wb_src)
    );

    always_comb begin
        W_wdata = 32'h0;
        unique case (wb_src)
            WB_ALU:  W_wdata = W_aluResult;
            WB_MEM:  W_wdata = W_dataOUT;
            WB_PC8:  W_wdata = W_PC8;
            default: W_wdata = 32'h0;
        endcase
    end

    // $0 destinations (e.g. jal/jalr into $0) are dropped here, so nothing downstream sees them.
    assign W_we = (wb_src != WB_NONE) && (W_writeReg_NUM != 5'd0);

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            grf_d[i] = (W_we && (W_writeReg_NUM == 5'(i))) ? W_wdata : grf_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) grf_q[i] <= 32'h0;
        end else begin
            for (int i = 1; i < 32; i++) grf_q[i] <= grf_d[i];
        end
    end

    always_comb begin
        grf_view[0] = 32'h0;
        for (int i = 1; i < 32; i++) grf_view[i] = grf_q[i];
    end

    // Reset gates the bypass too, so reads are zero while reset is held
    // even if the W bundle still carries a write.
    always_comb begin
        D_rs_data = 32'h0;
        if (reset && (D_rs_NUM != 5'd0)) begin
            if (W_we && (D_rs_NUM == W_writeReg_NUM))
                D_rs_data = W_wdata;
            else
                D_rs_data = grf_view[D_rs_NUM];
        end
    end

    always_comb begin
        D_rt_data = 32'h0;
        if (reset && (D_rt_NUM != 5'd0)) begin
            if (W_we && (D_rt_NUM == W_writeReg_NUM))
                D_rt_data = W_wdata;
            else
                D_rt_data = grf_view[D_rt_NUM];
        end
    end

    always_comb begin
        instret_d = instret_q;
        if ((W_inStr != 32'h0) && (W_PC != RESET_PC))
            instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) instret_q <= 32'h0;
        else        instret_q <= instret_d;
    end

    assign instret     = instret_q;
    assign trace_valid = W_we;
    assign trace_pc    = W_PC;
    assign trace_reg   = W_writeReg_NUM;
    assign trace_data  = W_wdata;

endmodule

// File: tb/tb_w_writeback_grf.sv
// tb/tb_w_writeback_grf.sv - self-checking bench for w_writeback_grf
module tb_w_writeback_grf;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    localparam logic [31:0] I_ORI   = 32'h3508_ABCD;
    localparam logic [31:0] I_LW    = 32'h8D09_0000;
    localparam logic [31:0] I_JALR  = 32'h03E0_F809;
    localparam logic [31:0] I_ADDU  = 32'h0000_0021;
    localparam logic [31:0] I_SW    = 32'hAC07_0000;
    localparam logic [31:0] I_BEQ   = 32'h1000_0001;
    localparam logic [31:0] I_JAL   = 32'h0C00_0100;
    localparam logic [31:0] I_LUI   = 32'h3C07_1234;
    localparam logic [31:0] I_ADDIU = 32'h240A_000A;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_J     = 32'h0800_0000;
    localparam logic [31:0] I_UNK   = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] W_PC, W_inStr, W_PC8, W_dataOUT, W_aluResult;
    logic [4:0]  W_writeReg_NUM, D_rs_NUM, D_rt_NUM;
    logic [31:0] D_rs_data, D_rt_data, W_wdata, trace_pc, trace_data, instret;
    logic        W_we, trace_valid;
    logic [4:0]  trace_reg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    w_writeback_grf #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .W_PC           (W_PC),
        .W_inStr        (W_inStr),
        .W_PC8          (W_PC8),
        .W_writeReg_NUM (W_writeReg_NUM),
        .W_dataOUT      (W_dataOUT),
        .W_aluResult    (W_aluResult),
        .D_rs_NUM       (D_rs_NUM),
        .D_rt_NUM       (D_rt_NUM),
        .D_rs_data      (D_rs_data),
        .D_rt_data      (D_rt_data),
        .W_we           (W_we),
        .W_wdata        (W_wdata),
        .trace_valid    (trace_valid),
        .trace_pc       (trace_pc),
        .trace_reg      (trace_reg),
        .trace_data     (trace_data),
        .instret        (instret)
    );

    typedef struct {
        logic [31:0] pc, instr, pc8;
        logic [4:0]  num;
        logic [31:0] dout, alu;
        logic [4:0]  rs, rt;
        logic        e_we;
        logic        chk_wd;
        logic [31:0] e_wd, e_rs, e_rt;
    } vec_t;

    typedef struct {
        logic        we;
        logic        chk_wd;
        logic [31:0] wd, rs, rt, ic, pc;
        logic [4:0]  num;
    } exp_t;

    vec_t tbl [13];
    exp_t sb [$];

    function automatic vec_t mk(input logic [31:0] pc, instr, pc8, input logic [4:0] num,
                                input logic [31:0] dout, alu, input logic [4:0] rs, rt,
                                input logic e_we, chk_wd, input logic [31:0] e_wd, e_rs, e_rt);
        vec_t v;
        v.pc = pc; v.instr = instr; v.pc8 = pc8; v.num = num; v.dout = dout; v.alu = alu;
        v.rs = rs; v.rt = rt; v.e_we = e_we; v.chk_wd = chk_wd;
        v.e_wd = e_wd; v.e_rs = e_rs; v.e_rt = e_rt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, instr, pc8, input logic [4:0] num,
                         input logic [31:0] dout, alu, input logic [4:0] rs, rt);
        W_PC = pc; W_inStr = instr; W_PC8 = pc8; W_writeReg_NUM = num;
        W_dataOUT = dout; W_aluResult = alu; D_rs_NUM = rs; D_rt_NUM = rt;
    endtask

    task automatic bubble(input logic [4:0] rs, rt);
        drive(32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, rs, rt);
    endtask

    initial begin
        logic [31:0] exp_cnt;
        exp_t e;

        //            pc          instr    pc8          num    dout          alu           rs     rt     we    chk   wd            rs            rt
        tbl[0]  = mk(32'h3004, I_ORI,   32'h0,       5'd8,  32'h0,        32'hABCD,     5'd8,  5'd0,  1'b1, 1'b1, 32'hABCD,     32'hABCD,     32'h0);
        tbl[1]  = mk(32'h3008, I_LW,    32'h0,       5'd9,  32'hDEADBEEF, 32'h1,        5'd8,  5'd9,  1'b1, 1'b1, 32'hDEADBEEF, 32'hABCD,     32'hDEADBEEF);
        tbl[2]  = mk(32'h3008, I_JALR,  32'h3010,    5'd31, 32'h0,        32'h55,       5'd31, 5'd9,  1'b1, 1'b1, 32'h3010,     32'h3010,     32'hDEADBEEF);
        tbl[3]  = mk(32'h3010, I_ADDU,  32'h0,       5'd0,  32'h0,        32'h5,        5'd0,  5'd31, 1'b0, 1'b1, 32'h5,        32'h0,        32'h3010);
        tbl[4]  = mk(32'h3014, I_SW,    32'h0,       5'd7,  32'h88,       32'h77,       5'd7,  5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        32'h0);
        tbl[5]  = mk(32'h3018, I_BEQ,   32'h0,       5'd7,  32'h88,       32'h77,       5'd7,  5'd9,  1'b0, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF);
        tbl[6]  = mk(32'h301C, I_JAL,   32'h9999,    5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  1'b0, 1'b1, 32'h9999,     32'h0,        32'h0);
        tbl[7]  = mk(32'h3020, I_LUI,   32'h0,       5'd7,  32'h0,        32'h12340000, 5'd7,  5'd7,  1'b1, 1'b1, 32'h12340000, 32'h12340000, 32'h12340000);
        tbl[8]  = mk(32'h3024, I_ADDIU, 32'h0,       5'd10, 32'h0,        32'hA,        5'd7,  5'd8,  1'b1, 1'b1, 32'hA,        32'h12340000, 32'hABCD);
        tbl[9]  = mk(RST_PC,   I_JR,    32'h0,       5'd7,  32'h0,        32'h1,        5'd7,  5'd10, 1'b0, 1'b0, 32'h0,        32'h12340000, 32'hA);
        tbl[10] = mk(32'h302C, 32'h0,   32'h0,       5'd7,  32'h0,        32'h9,        5'd7,  5'd10, 1'b0, 1'b0, 32'h0,        32'h12340000, 32'hA);
        tbl[11] = mk(32'h3030, I_J,     32'h0,       5'd3,  32'h0,        32'h3,        5'd3,  5'd31, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3010);
        tbl[12] = mk(32'h3034, I_UNK,   32'h0,       5'd4,  32'h0,        32'h4,        5'd4,  5'd9,  1'b0, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF);

        rst_n = 1'b0;
        bubble(5'd8, 5'd31);
        repeat (2) @(negedge clk);
        chk("reset_instret", instret, 32'h0);
        chk("reset_rs", D_rs_data, 32'h0);
        chk("reset_rt", D_rt_data, 32'h0);
        rst_n = 1'b1;

        exp_cnt = 32'h0;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].pc, tbl[i].instr, tbl[i].pc8, tbl[i].num,
                  tbl[i].dout, tbl[i].alu, tbl[i].rs, tbl[i].rt);
            e.we = tbl[i].e_we; e.chk_wd = tbl[i].chk_wd; e.wd = tbl[i].e_wd;
            e.rs = tbl[i].e_rs; e.rt = tbl[i].e_rt; e.ic = exp_cnt;
            e.pc = tbl[i].pc; e.num = tbl[i].num;
            sb.push_back(e);
            if (tbl[i].instr != 32'h0 && tbl[i].pc != RST_PC) exp_cnt = exp_cnt + 32'd1;

            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d_we", i), {31'h0, W_we}, {31'h0, e.we});
            if (e.chk_wd) chk($sformatf("v%0d_wdata", i), W_wdata, e.wd);
            chk($sformatf("v%0d_rs", i), D_rs_data, e.rs);
            chk($sformatf("v%0d_rt", i), D_rt_data, e.rt);
            chk($sformatf("v%0d_instret", i), instret, e.ic);
            chk($sformatf("v%0d_tvalid", i), {31'h0, trace_valid}, {31'h0, e.we});
            chk($sformatf("v%0d_tpc", i), trace_pc, e.pc);
            chk($sformatf("v%0d_treg", i), {27'h0, trace_reg}, {27'h0, e.num});
            if (e.chk_wd) chk($sformatf("v%0d_tdata", i), trace_data, e.wd);
        end

        // Final count after the last vector's edge: 9 counted, RESET_PC jr and bubble skipped, j and unknown counted.
        @(posedge clk); #1;
        drive(32'h3100, I_ADDIU, 32'h0, 5'd5, 32'h0, 32'h1234, 5'd5, 5'd8);
        chk("table_instret", instret, 32'd11);
        @(negedge clk);
        chk("r5_bypass", D_rs_data, 32'h1234);

        // Reset asserted between edges clears the array and counter at once.
        @(posedge clk); #1;
        bubble(5'd5, 5'd8);
        #1;
        chk("r5_array", D_rs_data, 32'h1234);
        chk("r8_array", D_rt_data, 32'hABCD);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rs", D_rs_data, 32'h0);
        chk("midreset_rt", D_rt_data, 32'h0);
        chk("midreset_instret", instret, 32'h0);
        drive(32'h3104, I_ORI, 32'h0, 5'd5, 32'h0, 32'h77, 5'd5, 5'd5);
        #1;
        chk("reset_bypass_gated", D_rs_data, 32'h0);
        @(posedge clk); #1;
        bubble(5'd5, 5'd8);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_r5", D_rs_data, 32'h0);
        chk("post_reset_r8", D_rt_data, 32'h0);

        // Three instructions then two bubbles retire exactly three.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(32'h3200 + 32'(4 * k), I_ADDU, 32'h0, 5'd0, 32'h0, 32'h5, 5'd0, 5'd0);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bubble(5'd0, 5'd0);
        end
        @(negedge clk);
        chk("count_3", instret, 32'd3);

        @(posedge clk); #1;
        drive(RST_PC, I_ORI, 32'h0, 5'd0, 32'h0, 32'h1, 5'd0, 5'd0);
        @(posedge clk); #1;
        bubble(5'd0, 5'd0);
        @(negedge clk);
        chk("count_reset_pc", instret, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
